bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with a run/pause/done controller: a kitchen-timer counterpart to the up-counting stopwatch chain.
- Digits are loaded one at a time from switch inputs. The count decrements on each 100 Hz tick, and the block stops at all-zero with a done indication.
- Sits between the 100 Hz tick source and the per-digit BCD-to-seven-segment decoders.
- Digit 0 is the least significant (hundredths).

Parameters:
- NUM_DIGITS, 6, number of BCD digits in the counter (range 1..8).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clock-wide enable pulse at 100 Hz; decrement strobe.
- wr_en  input  1  one-clock pulse; writes wr_data into digit wr_sel.
- wr_sel  input  3  digit index to write (0 = LSD).
- wr_data  input  4  BCD value to write.
- start  input  1  one-clock pulse; begin or resume counting.
- pause  input  1  one-clock pulse; suspend counting.
- digits  output  4*NUM_DIGITS  current count; digit i is at bits [4i+3:4i].
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- expired  output  1  one-clock pulse on entry to DONE.

Behaviour:
- Reset (synchronous, active-high, takes effect at the next clock edge even mid-count):
  - digits = 0, state = IDLE, running = 0, done = 0, expired = 0.
- States are IDLE, RUN, PAUSED, DONE.
  - running = (state == RUN).
  - done = (state == DONE).
  - Outputs are registered.
- Writes:
  - Accepted only in IDLE, PAUSED or DONE; ignored in RUN.
  - A write in DONE also moves the state to IDLE.
  - wr_data > 9 is clamped to 9.
  - wr_sel >= NUM_DIGITS: write is ignored.
  - The written digit is visible on digits the next cycle.
- start in IDLE or PAUSED:
  - If digits == 0: go to DONE and pulse expired the next cycle.
  - Otherwise: go to RUN.
  - start in RUN or DONE is ignored.
- pause in RUN goes to PAUSED; ignored in other states.
- Same-cycle priority: reset > pause > start > wr_en.
- Same cycle as a start or pause transition, tick is not applied.
- Decrement (tick == 1 in RUN, no pause):
  - Digit 0 decrements.
  - A digit at 0 receiving a borrow wraps to 9 and propagates the borrow upward, in one cycle (combinational borrow chain).
  - Example: 010000 -> 009999.
- Terminal count: a tick that makes digits == 0 moves the state to DONE in the same edge, with expired = 1 for exactly that next cycle.
  - Example: 000001 -> 000000, then DONE.
- DONE:
  - No decrement; digits are held at 0 and never underflow.
  - start is ignored; a write returns the block to IDLE.
- tick outside RUN has no effect.
- tick continuous every cycle is legal and decrements every cycle.
- Latency: one clock from any input strobe to the registered output change.

Decomposition:
- Shared package:
  - State enumeration (IDLE, RUN, PAUSED, DONE) as 2-bit constants.
  - BCD_MAX = 4'd9.
  - BCD_WIDTH = 4.
- Sub-module bcd_down_digit, one instance per digit:
  - Inputs: clock, reset, load, load_value, borrow_in.
  - Outputs: value, borrow_out.
  - borrow_out = borrow_in && value == 0.
  - The top-level generate chains borrow_out into borrow_in.
- The controller FSM stays in the top module.

Test Plan:
- Reset, then write digits to 000105, then start, then 105 ticks -> digits reach 000000 exactly on the 105th tick; expired high for 1 cycle; done = 1; running = 0.
- Load 010000, start, 1 tick -> digits = 009999 in one cycle (full borrow chain).
- Load 000050, start, 10 ticks, pause, 20 ticks, then start, 40 ticks -> digits hold 000040 while PAUSED; done asserts after the 40th resumed tick.
- All-zero start: reset, start -> DONE and expired pulse next cycle; further ticks leave digits = 000000 (no underflow to 999999).
- Write wr_sel = 2, wr_data = 12 -> digit 2 = 9. wr_sel = 7 -> no change. Write during RUN -> ignored. Write in DONE -> state returns to IDLE.
- Same-cycle start+pause in PAUSED -> remains PAUSED. reset asserted mid-RUN together with tick -> all outputs zero next cycle, state IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg: shared state encoding and BCD constants for the countdown timer
package bcd_countdown_timer_pkg;
  localparam int BCD_WIDTH = 4;
  localparam logic [BCD_WIDTH-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control/load strobes in, BCD count and status out
//   tick, wr_en, wr_sel, wr_data, start, pause : master -> slave
//   digits, running, done, expired             : slave -> master
interface bcd_countdown_timer_if #(parameter int NUM_DIGITS = 6);
  logic tick;
  logic wr_en;
  logic [2:0] wr_sel;
  logic [3:0] wr_data;
  logic start;
  logic pause;
  logic [4*NUM_DIGITS-1:0] digits;
  logic running;
  logic done;
  logic expired;
  modport master (output tick, wr_en, wr_sel, wr_data, start, pause, input digits, running, done, expired);
  modport slave (input tick, wr_en, wr_sel, wr_data, start, pause, output digits, running, done, expired);
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// bcd_down_digit: one loadable BCD digit that decrements on borrow_in and wraps 0 -> 9
//   clock, reset : clock and synchronous active-high reset
//   load, load_value : parallel load (takes precedence over borrow)
//   borrow_in, borrow_out : borrow chain; borrow_out is combinational
//   value : registered digit value
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BCD_WIDTH-1:0] load_value,
  input  logic                 borrow_in,
  output logic [BCD_WIDTH-1:0] value,
  output logic                 borrow_out
);
  logic [BCD_WIDTH-1:0] r_value;
  always_ff @(posedge clock)
    if (reset) r_value <= '0;
    else if (load) r_value <= load_value;
    else if (borrow_in) r_value <= (r_value == '0) ? BCD_MAX : r_value - 1'b1;
  assign value = r_value;
  assign borrow_out = borrow_in && r_value == '0;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with IDLE/RUN/PAUSED/DONE control
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : tick/wr_en/wr_sel/wr_data/start/pause in; digits/running/done/expired out
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input logic clock,
  input logic reset,
  bcd_countdown_timer_if.slave bus
);
  state_t r_state, w_state_nxt;
  logic r_expired;
  logic [BCD_WIDTH*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS-1:0] w_borrow;
  logic [BCD_WIDTH-1:0] w_wr_val;
  logic w_idle_or_paused, w_zero, w_one, w_dec, w_wr;
  // pause outranks start, which outranks a write, whether or not the higher one takes effect
  assign w_idle_or_paused = r_state == IDLE || r_state == PAUSED;
  assign w_zero = w_digits == '0;
  assign w_one = w_digits == (BCD_WIDTH*NUM_DIGITS)'(1);
  assign w_dec = r_state == RUN && bus.tick && !bus.pause;
  assign w_wr = bus.wr_en && !bus.pause && !bus.start && r_state != RUN && int'(bus.wr_sel) < NUM_DIGITS;
  assign w_wr_val = (bus.wr_data > BCD_MAX) ? BCD_MAX : bus.wr_data;
  assign w_borrow[0] = w_dec;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic w_borrow_out;
    bcd_down_digit u_digit (
      .clock(clock),
      .reset(reset),
      .load(w_wr && int'(bus.wr_sel) == i),
      .load_value(w_wr_val),
      .borrow_in(w_borrow[i]),
      .value(w_digits[BCD_WIDTH*i +: BCD_WIDTH]),
      .borrow_out(w_borrow_out)
    );
    if (i < NUM_DIGITS - 1) begin : g_chain
      assign w_borrow[i+1] = w_borrow_out;
    end else begin : g_top
      logic w_unused;
      assign w_unused = w_borrow_out;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= IDLE;
      r_expired <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_expired <= w_state_nxt == DONE && r_state != DONE;
    end
  always_comb begin
    w_state_nxt = r_state;
    if (bus.pause) w_state_nxt = (r_state == RUN) ? PAUSED : r_state;
    else if (bus.start && w_idle_or_paused) w_state_nxt = w_zero ? DONE : RUN;
    else if (w_wr && r_state == DONE) w_state_nxt = IDLE;
    else if (w_dec && w_one) w_state_nxt = DONE;
  end
  assign bus.digits = w_digits;
  assign bus.running = r_state == RUN;
  assign bus.done = r_state == DONE;
  assign bus.expired = r_expired;
endmodule
